sample_decimator: RTL
=====================

Name: sample_decimator

Overview:
- Sits directly downstream of the IIR filter stage in the analogue acquisition path.
- Consumes the filtered sample stream and reduces the rate by a programmable power-of-two factor before capture buffering.
- Supports three decimation modes:
  - subsample (keep the first sample of each window);
  - average (boxcar mean over the window);
  - peak detect (min and max over the window, for glitch capture at slow timebases).

Parameters:
- X_WIDTH, 12, input sample width, signed two's complement.
- MAX_LOG2, 8, largest supported decimation exponent; factor range is 1..2^MAX_LOG2.
- LOG2_WIDTH, 4, width of the ratio_log2 port; must satisfy 2^LOG2_WIDTH > MAX_LOG2.

Ports:
- clk, input, 1, sample clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, x holds a new sample this cycle.
- x, input, X_WIDTH, signed input sample from the filter stage.
- ratio_log2, input, LOG2_WIDTH, decimation factor D = 2^ratio_log2; values above MAX_LOG2 are clamped to MAX_LOG2.
- mode, input, 2, 0 = subsample, 1 = average, 2 = peak, 3 = reserved (behaves as subsample).
- sync_clr, input, 1, discard the partial window and restart counting (used on trigger re-arm).
- out_valid, output, 1, single-cycle strobe: y, y_min and y_max hold a new decimated result.
- y, output, X_WIDTH, signed result. Subsample: first sample. Average: mean. Peak: equals y_max.
- y_min, output, X_WIDTH, signed window minimum. Valid in peak mode; equals y in other modes.
- y_max, output, X_WIDTH, signed window maximum. Valid in peak mode; equals y in other modes.

Behaviour:
- Reset (asynchronous, rst_n low):
  - out_valid = 0; y = y_min = y_max = 0.
  - Window counter = 0; accumulator = 0; latched config = subsample with D = 1.
  - Takes effect immediately, including mid-window; the partial window is lost.
- Config latch:
  - ratio_log2 (after clamping) and mode are latched on the first accepted sample of each window, i.e. in_valid=1 with counter=0.
  - Changes mid-window have no effect until the next window starts.
- Window counter:
  - Width MAX_LOG2+1; increments on each in_valid.
  - When counter reaches D-1 and in_valid=1, the window completes and the counter returns to 0.
- Accumulation, by latched mode:
  - Subsample: hold the first sample of the window.
  - Average: signed sum register of X_WIDTH+MAX_LOG2 bits. First sample loads the sum; later samples add. No overflow is possible by construction.
  - Peak: running min and max registers. First sample loads both; later samples use signed compares.
- Output:
  - On window completion, in the next cycle out_valid=1 for exactly one cycle with results registered. Latency is 1 clk after the final sample of the window.
  - Average result = sum arithmetically shifted right by ratio_log2, i.e. truncation toward minus infinity.
  - Outputs hold their values between strobes; out_valid is 0 otherwise.
- D = 1 (ratio_log2 = 0):
  - Every valid sample produces out_valid one cycle later with y = y_min = y_max = x in all modes.
  - Back-to-back in_valid gives back-to-back out_valid; no bubbles at any D.
- in_valid gaps: idle cycles inside a window are ignored; no timeout.
- sync_clr:
  - Synchronous, highest priority over window progress.
  - Counter and accumulators clear; no out_valid is produced for the discarded window.
  - If in_valid=1 in the same cycle, that sample is accepted as sample 0 of a new window, and config is latched from that cycle.
  - A completion strobe already scheduled (window completed the previous cycle) still emits.
- Simultaneous window completion and first sample of the next window: impossible in one cycle, since one sample is accepted per cycle. The sample after completion starts the new window with no lost cycle.

Test Plan:
- Reset mid-window: mode 1, D=4, feed 10, 20, assert rst_n low for 1 cycle, release, feed 1, 2, 3, 4 -> exactly one out_valid, y=2 (sum 10 >>> 2); no strobe from the aborted window.
- Subsample D=4: continuous in_valid with x = 0,1,2,…,11 -> out_valid on cycles 4, 8, 12 after the first sample, with y = 0, 4, 8 and no gaps.
- Average with negatives: D=2, samples -3, -2 -> y = -3 (sum -5 >>> 1, floor). Then D=1, sample -7 -> y = -7 one cycle later.
- Peak: D=8, samples 5, -100, 30, 2047, -2048, 0, 1, 1 -> y_min = -2048, y_max = y = 2047.
- Config change mid-window: D=4 latched; after 2 samples set ratio_log2=1 -> strobe still after the 4th sample. The next window uses D=2. ratio_log2=15 clamps to 8 (strobe every 256 samples).
- sync_clr: D=4, 3 samples, then sync_clr with in_valid, x=9, then 3 more samples 9, 9, 9 in mode 1 -> single strobe, y=9. Random in_valid gaps (~50% duty) give identical results to the gap-free run.

Source files
------------

// File: rtl/sample_decimator.sv
// sample_decimator: power-of-two rate reduction by subsample, boxcar average or min/max peak detect
// Ports: clk, rst_n (async active-low); in_valid/x sample in; ratio_log2 (clamped to MAX_LOG2), mode
// (0 subsample, 1 average, 2 peak, 3 as subsample), sync_clr window restart; out_valid strobe with y, y_min, y_max.
module sample_decimator #(
  parameter int X_WIDTH    = 12,
  parameter int MAX_LOG2   = 8,
  parameter int LOG2_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic signed [X_WIDTH-1:0] x,
  input  logic [LOG2_WIDTH-1:0]     ratio_log2,
  input  logic [1:0]                mode,
  input  logic                      sync_clr,
  output logic                      out_valid,
  output logic signed [X_WIDTH-1:0] y,
  output logic signed [X_WIDTH-1:0] y_min,
  output logic signed [X_WIDTH-1:0] y_max
);
  localparam int CW = MAX_LOG2 + 1;
  localparam int SW = X_WIDTH + MAX_LOG2;
  logic [CW-1:0] cnt, cnt_e;
  logic [LOG2_WIDTH-1:0] l_q, l_in, l_e;
  logic [1:0] m_q, m_e;
  logic signed [SW-1:0] sum, sum_n, avg;
  logic signed [X_WIDTH-1:0] hold, hold_n, mn, mn_n, mx, mx_n, res;
  logic start, done;
  // The accumulators' next values fold in the current sample so a completing
  // window (including D=1) registers its result straight from them.
  always_comb begin
    l_in   = ratio_log2 > LOG2_WIDTH'(MAX_LOG2) ? LOG2_WIDTH'(MAX_LOG2) : ratio_log2;
    cnt_e  = sync_clr ? '0 : cnt;
    start  = in_valid && cnt_e == '0;
    l_e    = start ? l_in : l_q;
    m_e    = start ? mode : m_q;
    done   = in_valid && cnt_e == CW'((CW'(1) << l_e) - CW'(1));
    hold_n = start ? x : hold;
    sum_n  = start ? SW'(x) : sum + SW'(x);
    mn_n   = (start || x < mn) ? x : mn;
    mx_n   = (start || x > mx) ? x : mx;
    avg    = sum_n >>> l_e;
    res    = m_e == 2'd1 ? avg[X_WIDTH-1:0] : m_e == 2'd2 ? mx_n : hold_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      l_q       <= '0;
      m_q       <= '0;
      sum       <= '0;
      hold      <= '0;
      mn        <= '0;
      mx        <= '0;
      out_valid <= 1'b0;
      y         <= '0;
      y_min     <= '0;
      y_max     <= '0;
    end else begin
      out_valid <= done;
      if (done) begin
        y     <= res;
        y_min <= m_e == 2'd2 ? mn_n : res;
        y_max <= m_e == 2'd2 ? mx_n : res;
      end
      if (sync_clr) begin
        cnt  <= '0;
        sum  <= '0;
        hold <= '0;
        mn   <= '0;
        mx   <= '0;
      end
      if (in_valid) begin
        cnt  <= done ? '0 : cnt_e + CW'(1);
        l_q  <= l_e;
        m_q  <= m_e;
        sum  <= sum_n;
        hold <= hold_n;
        mn   <= mn_n;
        mx   <= mx_n;
      end
    end
  end
endmodule
